// File: rtl/lcd_msg_scheduler.sv
// lcd_msg_scheduler: two-requester priority intake, 4-deep code FIFO and textlcd write/hold sequencer.
// Build option LCD_MSG_DEDUP_EN discards codes repeating the FIFO tail or the code on screen.
module lcd_msg_scheduler #(
  parameter int unsigned HOLD_CYCLES = 1000,
  parameter int unsigned WR_TIMEOUT  = 4096,
  parameter logic [2:0]  IDLE_CMD    = 3'b110
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_a_valid,
  input  logic [2:0] req_a_cmd,
  output logic       req_a_ready,
  input  logic       req_b_valid,
  input  logic [2:0] req_b_cmd,
  output logic       req_b_ready,
  output logic [2:0] lcd_cmd,
  output logic       lcd_start,
  input  logic       lcd_done,
  output logic       busy,
  output logic [2:0] fifo_count,
  output logic [7:0] drop_cnt
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int TW = (WR_TIMEOUT > 1) ? $clog2(WR_TIMEOUT) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
  localparam logic [HW-1:0] HOLD_ZERO = HW'(0);
  localparam logic [TW-1:0] TO_LAST   = TW'(WR_TIMEOUT - 1);
  localparam logic [TW-1:0] TO_ONE    = TW'(1);
  localparam logic [TW-1:0] TO_ZERO   = TW'(0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WRITE = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t        state_r, state_nx_s;
  logic [2:0]    fifo_mem_r [4];
  logic [1:0]    wr_ptr_r, rd_ptr_r;
  logic [2:0]    count_r, count_nx_s;
  logic          accept_en_r;
  logic [HW-1:0] hold_cnt_r, hold_cnt_nx_s;
  logic [TW-1:0] to_cnt_r, to_cnt_nx_s;
  logic [2:0]    lcd_cmd_r;
  logic          lcd_start_r, busy_r;
  logic [7:0]    drop_cnt_r, drop_nx_s;
  logic          has_room_s, push_a_s, push_b_s, push_s, dup_s, store_s;
  logic          pop_s, timeout_s;
  logic [2:0]    push_code_s;
  logic [1:0]    drop_inc_s;
`ifdef LCD_MSG_DEDUP_EN
  logic [2:0]    tail_s;
`endif

  // Ready uses the registered count only, so a full FIFO refuses even while popping.
  assign req_a_ready = has_room_s;
  assign req_b_ready = has_room_s && !req_a_valid;
  assign lcd_cmd     = lcd_cmd_r;
  assign lcd_start   = lcd_start_r;
  assign busy        = busy_r;
  assign fifo_count  = count_r;
  assign drop_cnt    = drop_cnt_r;

  // Intake arbitration, duplicate filter, occupancy and drop counter next values.
  always_comb begin
    has_room_s  = accept_en_r && (count_r < 3'd4);
    push_a_s    = req_a_valid && has_room_s;
    push_b_s    = req_b_valid && has_room_s && !req_a_valid;
    push_s      = push_a_s || push_b_s;
    push_code_s = push_a_s ? req_a_cmd : req_b_cmd;
`ifdef LCD_MSG_DEDUP_EN
    tail_s = fifo_mem_r[wr_ptr_r - 2'd1];
    if (count_r != 3'd0) begin
      dup_s = push_s && (push_code_s == tail_s);
    end else begin
      dup_s = push_s && busy_r && (push_code_s == lcd_cmd_r);
    end
`else
    dup_s = 1'b0;
`endif
    store_s = push_s && !dup_s;
    case ({store_s, pop_s})
      2'b10:   count_nx_s = count_r + 3'd1;
      2'b01:   count_nx_s = count_r - 3'd1;
      default: count_nx_s = count_r;
    endcase
    drop_inc_s = {1'b0, timeout_s} + {1'b0, dup_s};
    if (drop_cnt_r > (8'd255 - {6'd0, drop_inc_s})) begin
      drop_nx_s = 8'd255;
    end else begin
      drop_nx_s = drop_cnt_r + {6'd0, drop_inc_s};
    end
  end

  // Sequencer next state: pop, strobe, wait for textlcd, then hold the message on screen.
  always_comb begin
    state_nx_s    = state_r;
    pop_s         = 1'b0;
    timeout_s     = 1'b0;
    hold_cnt_nx_s = hold_cnt_r;
    to_cnt_nx_s   = to_cnt_r;
    case (state_r)
      S_IDLE: begin
        if (count_r != 3'd0) begin
          pop_s      = 1'b1;
          state_nx_s = S_START;
        end else begin
          state_nx_s = S_IDLE;
        end
      end
      S_START: begin
        to_cnt_nx_s = TO_ZERO;
        state_nx_s  = S_WRITE;
      end
      S_WRITE: begin
        if (lcd_done) begin
          hold_cnt_nx_s = HOLD_LOAD;
          to_cnt_nx_s   = TO_ZERO;
          state_nx_s    = S_HOLD;
        end else if (to_cnt_r == TO_LAST) begin
          timeout_s   = 1'b1;
          to_cnt_nx_s = TO_ZERO;
          state_nx_s  = S_IDLE;
        end else begin
          to_cnt_nx_s = to_cnt_r + TO_ONE;
        end
      end
      S_HOLD: begin
        if (hold_cnt_r != HOLD_ZERO) begin
          hold_cnt_nx_s = hold_cnt_r - HOLD_ONE;
        end else if (count_r != 3'd0) begin
          pop_s      = 1'b1;
          state_nx_s = S_START;
        end else begin
          state_nx_s = S_IDLE;
        end
      end
      default: state_nx_s = S_IDLE;
    endcase
  end

  // State, FIFO storage and registered LCD-side outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= S_IDLE;
      for (int i = 0; i < 4; i++) begin
        fifo_mem_r[i] <= 3'd0;
      end
      wr_ptr_r    <= 2'd0;
      rd_ptr_r    <= 2'd0;
      count_r     <= 3'd0;
      accept_en_r <= 1'b0;
      hold_cnt_r  <= HOLD_ZERO;
      to_cnt_r    <= TO_ZERO;
      lcd_cmd_r   <= IDLE_CMD;
      lcd_start_r <= 1'b0;
      busy_r      <= 1'b0;
      drop_cnt_r  <= 8'd0;
    end else begin
      state_r     <= state_nx_s;
      count_r     <= count_nx_s;
      accept_en_r <= 1'b1;
      hold_cnt_r  <= hold_cnt_nx_s;
      to_cnt_r    <= to_cnt_nx_s;
      lcd_start_r <= (state_nx_s == S_START);
      busy_r      <= (state_nx_s != S_IDLE);
      drop_cnt_r  <= drop_nx_s;
      if (store_s) begin
        fifo_mem_r[wr_ptr_r] <= push_code_s;
        wr_ptr_r             <= wr_ptr_r + 2'd1;
      end
      if (pop_s) begin
        lcd_cmd_r <= fifo_mem_r[rd_ptr_r];
        rd_ptr_r  <= rd_ptr_r + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_lcd_msg_scheduler.sv
// Directed bench for lcd_msg_scheduler with a display-order scoreboard and a textlcd done responder.
module tb_lcd_msg_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_a_valid, req_b_valid;
  logic [2:0] req_a_cmd, req_b_cmd;
  logic       req_a_ready, req_b_ready;
  logic [2:0] lcd_cmd;
  logic       lcd_start;
  logic       lcd_done;
  logic       busy;
  logic [2:0] fifo_count;
  logic [7:0] drop_cnt;

  int checks = 0;
  int errors = 0;
  logic [2:0] sb [$];
  int done_delay = 3;
  int done_cnt = 0;
  int start_cnt = 0;
  int exp_drop = 0;
  int s0;

  lcd_msg_scheduler #(.HOLD_CYCLES(8), .WR_TIMEOUT(16), .IDLE_CMD(3'b110)) dut (
    .clk(clk), .rst(rst),
    .req_a_valid(req_a_valid), .req_a_cmd(req_a_cmd), .req_a_ready(req_a_ready),
    .req_b_valid(req_b_valid), .req_b_cmd(req_b_cmd), .req_b_ready(req_b_ready),
    .lcd_cmd(lcd_cmd), .lcd_start(lcd_start), .lcd_done(lcd_done),
    .busy(busy), .fifo_count(fifo_count), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive A at a falling edge, wait (bounded) for ready, record the expected display code.
  task automatic send_a(input logic [2:0] code, input bit store);
    int n;
    n = 0;
    req_a_valid = 1'b1;
    req_a_cmd   = code;
    #1;
    while (req_a_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("a_handshake", 32'(req_a_ready), 32'd1);
    if (req_a_ready === 1'b1 && store) sb.push_back(code);
    @(negedge clk);
    req_a_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (!(busy === 1'b0 && fifo_count === 3'd0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("idle_reached", 32'(busy === 1'b0 && fifo_count === 3'd0), 32'd1);
  endtask

  // textlcd model: pulse lcd_done done_delay cycles after lcd_start (0 = never answer).
  initial begin
    lcd_done = 1'b0;
    forever begin
      @(negedge clk);
      lcd_done = 1'b0;
      if (rst === 1'b1) begin
        done_cnt = 0;
      end else if (done_cnt > 0) begin
        done_cnt--;
        if (done_cnt == 0) lcd_done = 1'b1;
      end else if (lcd_start === 1'b1 && done_delay > 0) begin
        done_cnt = done_delay;
      end
    end
  end

  // Scoreboard: every lcd_start must show the oldest accepted code.
  initial begin
    forever begin
      @(negedge clk);
      if (lcd_start === 1'b1) begin
        start_cnt++;
        chk("start_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) chk("lcd_cmd_order", 32'(lcd_cmd), 32'(sb.pop_front()));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req_a_valid = 1'b0; req_a_cmd = 3'd0;
    req_b_valid = 1'b0; req_b_cmd = 3'd0;
    repeat (3) @(negedge clk);
    chk("rst_fifo_count", 32'(fifo_count), 32'd0);
    chk("rst_lcd_cmd", 32'(lcd_cmd), 32'd6);
    chk("rst_lcd_start", 32'(lcd_start), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);

    // First cycle after release must not accept.
    rst = 1'b0;
    req_a_valid = 1'b1; req_a_cmd = 3'b111;
    #1;
    chk("no_accept_after_rst", 32'(req_a_ready), 32'd0);
    @(negedge clk);
    chk("no_store_after_rst", 32'(fifo_count), 32'd0);
    req_a_valid = 1'b0;

    // Single message: 2-cycle start latency, 8-cycle hold.
    send_a(3'b010, 1'b1);
    chk("t1_queued", 32'(fifo_count), 32'd1);
    chk("t1_no_start_yet", 32'(lcd_start), 32'd0);
    @(negedge clk);
    chk("t1_start", 32'(lcd_start), 32'd1);
    chk("t1_cmd", 32'(lcd_cmd), 32'd2);
    chk("t1_busy", 32'(busy), 32'd1);
    repeat (11) @(negedge clk);
    chk("t1_busy_in_hold", 32'(busy), 32'd1);
    @(negedge clk);
    chk("t1_idle_after_hold", 32'(busy), 32'd0);
    chk("t1_cmd_kept", 32'(lcd_cmd), 32'd2);

    // A and B together: A first, B next cycle.
    req_a_valid = 1'b1; req_a_cmd = 3'b000;
    req_b_valid = 1'b1; req_b_cmd = 3'b011;
    #1;
    chk("t2_a_ready", 32'(req_a_ready), 32'd1);
    chk("t2_b_blocked", 32'(req_b_ready), 32'd0);
    sb.push_back(3'b000);
    @(negedge clk);
    req_a_valid = 1'b0;
    #1;
    chk("t2_b_ready", 32'(req_b_ready), 32'd1);
    chk("t2_only_a_stored", 32'(fifo_count), 32'd1);
    sb.push_back(3'b011);
    @(negedge clk);
    req_b_valid = 1'b0;
    chk("t2_push_pop_count", 32'(fifo_count), 32'd1);
    wait_idle(200);
    chk("t2_sb_drained", 32'(sb.size()), 32'd0);

    // Repeated code while busy on it.
    send_a(3'b010, 1'b1);
    @(negedge clk);
`ifdef LCD_MSG_DEDUP_EN
    send_a(3'b010, 1'b0);
    send_a(3'b010, 1'b0);
    exp_drop = 2;
    chk("t4_dedup_count", 32'(fifo_count), 32'd0);
`else
    send_a(3'b010, 1'b1);
    send_a(3'b010, 1'b1);
    exp_drop = 0;
    chk("t4_stored_count", 32'(fifo_count), 32'd2);
`endif
    chk("t4_drop_cnt", 32'(drop_cnt), 32'(exp_drop));
    wait_idle(200);
    chk("t4_sb_drained", 32'(sb.size()), 32'd0);

    // Stalled write: fill FIFO, hold fifth request, time out, resume.
    done_delay = 0;
    send_a(3'b001, 1'b1);
    send_a(3'b010, 1'b1);
    send_a(3'b011, 1'b1);
    send_a(3'b100, 1'b1);
    send_a(3'b101, 1'b1);
    chk("t3_full_count", 32'(fifo_count), 32'd4);
    chk("t3_a_not_ready", 32'(req_a_ready), 32'd0);
    chk("t3_b_not_ready", 32'(req_b_ready), 32'd0);
    req_a_valid = 1'b1; req_a_cmd = 3'b110;
    repeat (14) @(negedge clk);
    exp_drop = exp_drop + 1;
    chk("t3_timeout_idle", 32'(busy), 32'd0);
    chk("t3_timeout_drop", 32'(drop_cnt), 32'(exp_drop));
    chk("t3_held_while_full", 32'(req_a_ready), 32'd0);
    chk("t3_still_full", 32'(fifo_count), 32'd4);
    done_delay = 3;
    @(negedge clk);
    #1;
    chk("t3_ready_after_pop", 32'(req_a_ready), 32'd1);
    chk("t3_count_after_pop", 32'(fifo_count), 32'd3);
    chk("t3_next_start", 32'(lcd_start), 32'd1);
    sb.push_back(3'b110);
    @(negedge clk);
    req_a_valid = 1'b0;
    chk("t3_fifth_stored", 32'(fifo_count), 32'd4);
    wait_idle(400);
    chk("t3_drop_final", 32'(drop_cnt), 32'(exp_drop));
    chk("t3_sb_drained", 32'(sb.size()), 32'd0);

    // Reset during hold with three queued.
    send_a(3'b101, 1'b1);
    send_a(3'b001, 1'b1);
    send_a(3'b011, 1'b1);
    send_a(3'b100, 1'b1);
    repeat (3) @(negedge clk);
    chk("t5_queued", 32'(fifo_count), 32'd3);
    chk("t5_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    sb.delete();
    chk("t5_rst_count", 32'(fifo_count), 32'd0);
    chk("t5_rst_cmd", 32'(lcd_cmd), 32'd6);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_drop", 32'(drop_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    s0 = start_cnt;
    repeat (20) @(negedge clk);
    chk("t5_no_start", 32'(start_cnt - s0), 32'd0);
    chk("t5_count_empty", 32'(fifo_count), 32'd0);
    chk("t5_cmd_idle", 32'(lcd_cmd), 32'd6);
    chk("t5_not_busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
